// File: rtl/matrix_acc_pkg.sv
// Shared constants and types for the 3x3 matrix multiply stream front/back end.
// The FSM state type, operand/result array types and an index helper live here.
package matrix_acc_pkg;

    localparam int MAT_DIM = 3;
    localparam int N_ELEM  = MAT_DIM * MAT_DIM;
    localparam int DAT_W   = 8;
    localparam int RES_W   = 16;
    localparam int IDX_W   = $clog2(N_ELEM);
    localparam int LAT_W   = 3;  // wide enough for a multiplier latency of up to 7

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        WAIT,
        DRAIN
    } mat_state_e;

    typedef logic [N_ELEM-1:0][DAT_W-1:0] op_mat_t;
    typedef logic [N_ELEM-1:0][RES_W-1:0] res_mat_t;
    typedef logic [IDX_W-1:0]             idx_t;

    function automatic logic is_last_elem(input idx_t idx);
        return idx == idx_t'(N_ELEM - 1);
    endfunction

endpackage

// File: rtl/matrix_result_serializer.sv
// Snapshots the multiplier result on a capture pulse and streams it out row-major
// over valid/ready, flagging the final element with out_last_o.
module matrix_result_serializer
    import matrix_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_i,
    input  logic             abort_i,
    input  res_mat_t         mat_c_i,
    output logic [RES_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             done_o
);

    res_mat_t res_buf_q, res_buf_d;
    idx_t     idx_q, idx_d;
    logic     valid_q, valid_d;
    logic     out_fire;

    assign out_fire = valid_q & out_ready_i;

    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        res_buf_d = res_buf_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        if (abort_i) begin
            idx_d   = '0;
            valid_d = 1'b0;
        end else if (capture_i) begin
            res_buf_d = mat_c_i;
            idx_d     = '0;
            valid_d   = 1'b1;
        end else if (out_fire) begin
            if (is_last_elem(idx_q)) begin
                idx_d   = '0;
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + idx_t'(1);
            end
        end
    end

    // NOTE: the result buffer is reset along with the control state because its reset value is architecturally visible on out_data_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_buf_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            res_buf_q <= res_buf_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
        end
    end

    assign out_data_o  = res_buf_q[idx_q];
    assign out_valid_o = valid_q;
    assign out_last_o  = valid_q & is_last_elem(idx_q);
    // An aborted cycle never counts as completing the drain.
    assign done_o      = out_fire & is_last_elem(idx_q) & ~abort_i;

endmodule

// File: rtl/matrix_stream_ctrl.sv
// Streaming front/back end for the 3x3 matrix multiplier: packs A then B operands,
// waits out the multiplier latency, then hands the result to the serializer.
module matrix_stream_ctrl
    import matrix_acc_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort_i,
    input  logic [DAT_W-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output op_mat_t          mat_A_o,
    output op_mat_t          mat_B_o,
    input  res_mat_t         mat_C_i,
    output logic [RES_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             busy_o
);

    mat_state_e       state_q, state_d;
    idx_t             elem_cnt_q, elem_cnt_d;
    logic [LAT_W-1:0] wait_cnt_q, wait_cnt_d;
    op_mat_t          mat_a_q, mat_a_d;
    op_mat_t          mat_b_q, mat_b_d;
    logic             capture;
    logic             drain_done;

    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mat_a_d    = mat_a_q;
        mat_b_d    = mat_b_q;
        capture    = 1'b0;
        in_ready_o = 1'b0;

        if (abort_i) begin
            // Abort wins over everything else; any element offered this cycle is dropped.
            state_d    = LOAD_A;
            elem_cnt_d = '0;
            wait_cnt_d = '0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        mat_a_d[elem_cnt_q] = in_data_i;
                        if (is_last_elem(elem_cnt_q)) begin
                            elem_cnt_d = '0;
                            state_d    = LOAD_B;
                        end else begin
                            elem_cnt_d = elem_cnt_q + idx_t'(1);
                        end
                    end
                end
                LOAD_B: begin
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        mat_b_d[elem_cnt_q] = in_data_i;
                        if (is_last_elem(elem_cnt_q)) begin
                            elem_cnt_d = '0;
                            wait_cnt_d = '0;
                            state_d    = WAIT;
                        end else begin
                            elem_cnt_d = elem_cnt_q + idx_t'(1);
                        end
                    end
                end
                WAIT: begin
                    // MUL_LAT+1 cycles: the last B element lands in mat_B_o, then the multiplier needs MUL_LAT more.
                    if (wait_cnt_q == LAT_W'(MUL_LAT)) begin
                        capture    = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + LAT_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_d = LOAD_A;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            elem_cnt_q <= '0;
            wait_cnt_q <= '0;
            mat_a_q    <= '0;
            mat_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
        end
    end

    matrix_result_serializer u_serializer (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture_i   (capture),
        .abort_i     (abort_i),
        .mat_c_i     (mat_C_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .done_o      (drain_done)
    );

    assign mat_A_o = mat_a_q;
    assign mat_B_o = mat_b_q;
    assign busy_o  = !((state_q == LOAD_A) && (elem_cnt_q == '0));

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// Randomized self-checking bench for matrix_stream_ctrl with a latency-3 multiplier
// stand-in and a plain-arithmetic matrix product as the reference model.
module tb_matrix_stream_ctrl;
    import matrix_acc_pkg::*;

    localparam int unsigned MUL_LAT = 3;

    typedef logic [DAT_W-1:0] elem_arr_t [N_ELEM];
    typedef logic [RES_W-1:0] res_arr_t  [N_ELEM];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             abort_i = 1'b0;
    logic [DAT_W-1:0] in_data_i = '0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    op_mat_t          mat_A_o, mat_B_o;
    res_mat_t         mat_C_i;
    logic [RES_W-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic             out_last_o;
    logic             busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    matrix_stream_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .abort_i     (abort_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mat_A_o     (mat_A_o),
        .mat_B_o     (mat_B_o),
        .mat_C_i     (mat_C_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    // Multiplier stand-in: combinational product followed by MUL_LAT register stages.
    res_mat_t prod_c;
    res_mat_t mul_pipe [MUL_LAT];
    always_comb begin
        prod_c = '0;
        for (int r = 0; r < MAT_DIM; r++)
            for (int c = 0; c < MAT_DIM; c++)
                for (int k = 0; k < MAT_DIM; k++)
                    prod_c[r*MAT_DIM+c] = prod_c[r*MAT_DIM+c]
                        + RES_W'(mat_A_o[r*MAT_DIM+k]) * RES_W'(mat_B_o[k*MAT_DIM+c]);
    end
    always_ff @(posedge clk) begin
        mul_pipe[0] <= prod_c;
        for (int i = 1; i < int'(MUL_LAT); i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign mat_C_i = mul_pipe[MUL_LAT-1];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    // Reference: textbook row-by-column product in wide integers, reduced modulo 2^RES_W.
    function automatic res_arr_t ref_matmul(input elem_arr_t a, input elem_arr_t b);
        res_arr_t res;
        for (int r = 0; r < MAT_DIM; r++)
            for (int c = 0; c < MAT_DIM; c++) begin
                longint acc = 0;
                for (int k = 0; k < MAT_DIM; k++)
                    acc += longint'(a[r*MAT_DIM+k]) * longint'(b[k*MAT_DIM+c]);
                res[r*MAT_DIM+c] = RES_W'(acc % 65536);
            end
        return res;
    endfunction

    task automatic send_elem(input logic [DAT_W-1:0] d, input int gap_max);
        int budget = 0;
        repeat ($urandom_range(gap_max, 0)) begin
            @(negedge clk);
            in_valid_i = 1'b0;
        end
        @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = d;
        #1;
        while (!in_ready_o && budget < 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!in_ready_o) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic load_op(input elem_arr_t a, input elem_arr_t b, input int gap_max);
        for (int i = 0; i < N_ELEM; i++) send_elem(a[i], gap_max);
        for (int i = 0; i < N_ELEM; i++) send_elem(b[i], gap_max);
    endtask

    // Consumes 'count' results; mode 0 always ready, 1 repeating 1,0,0,1, 2 random.
    task automatic drain(input res_arr_t exp, input int mode, input int count);
        int idx = 0;
        int cyc = 0;
        while (idx < count && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            case (mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready_i = 1'($urandom_range(1, 0));
            endcase
            cyc++;
            #1;
            check("out_valid", 32'(out_valid_o), 32'd1);
            check("out_data", 32'(out_data_o), 32'(exp[idx]));
            check("out_last", 32'(out_last_o), 32'(idx == N_ELEM - 1));
            check("in_ready_in_drain", 32'(in_ready_o), 32'd0);
            if (out_ready_i) idx++;
        end
        if (idx < count) check("drain_timeout", 32'(idx), 32'(count));
    endtask

    // Loads an operation, checks the WAIT latency, and optionally drains part or all of it.
    task automatic run_op(input elem_arr_t a, input elem_arr_t b, input res_arr_t exp,
                          input int gap_max, input int mode, input int count);
        int k = 0;
        load_op(a, b, gap_max);
        do begin
            @(negedge clk);
            in_valid_i = 1'b0;
            k++;
            #1;
            if (k == 1) begin
                check("wait_in_ready", 32'(in_ready_o), 32'd0);
                check("wait_busy", 32'(busy_o), 32'd1);
            end
        end while (!out_valid_o && k < 50);
        check("first_valid_latency", 32'(k - 1), MUL_LAT + 1);
        drain(exp, mode, count);
        if (count == N_ELEM) begin
            @(negedge clk);
            out_ready_i = 1'b0;
            #1;
            check("post_drain_valid", 32'(out_valid_o), 32'd0);
            check("post_drain_last", 32'(out_last_o), 32'd0);
            check("post_drain_in_ready", 32'(in_ready_o), 32'd1);
            check("post_drain_busy", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        elem_arr_t a_id, b_seq, a_seq, b_rev, a_ff, a_r, b_r;
        res_arr_t  exp_seq, exp_ff, exp_t3, exp_r;
        logic [DAT_W-1:0] kept_a5;

        for (int i = 0; i < N_ELEM; i++) begin
            a_id[i]    = (i % (MAT_DIM + 1) == 0) ? 8'd1 : 8'd0;
            b_seq[i]   = DAT_W'(i + 1);
            a_seq[i]   = DAT_W'(i + 1);
            b_rev[i]   = DAT_W'(N_ELEM - i);
            a_ff[i]    = 8'hFF;
            exp_seq[i] = RES_W'(i + 1);
            exp_ff[i]  = 16'd64003;
        end
        exp_t3 = '{16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54, 16'd138, 16'd114, 16'd90};

        // Reset values while rst_n is held low.
        #2;
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_last", 32'(out_last_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_mats_zero", 32'((mat_A_o == '0) && (mat_B_o == '0)), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity times 1..9, back-to-back loads, always-ready drain.
        run_op(a_id, b_seq, exp_seq, 0, 0, N_ELEM);
        // Truncation case.
        run_op(a_ff, a_ff, exp_ff, 0, 0, N_ELEM);
        // 1..9 times 9..1 under the 1,0,0,1 ready pattern.
        run_op(a_seq, b_rev, exp_t3, 0, 1, N_ELEM);
        // Same operands with random input gaps and random back-pressure.
        run_op(a_seq, b_rev, exp_t3, 3, 2, N_ELEM);

        // Abort after five A elements: element in the abort cycle must be dropped.
        kept_a5 = mat_A_o[5];
        for (int i = 0; i < 5; i++) send_elem(a_id[i], 0);
        @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = 8'hAA;
        abort_i    = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready_o), 32'd0);
        check("abort_busy_before", 32'(busy_o), 32'd1);
        @(negedge clk);
        abort_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("abort_busy_after", 32'(busy_o), 32'd0);
        check("abort_in_ready_after", 32'(in_ready_o), 32'd1);
        check("abort_elem_dropped", 32'(mat_A_o[5]), 32'(kept_a5));
        run_op(a_id, b_seq, exp_seq, 0, 0, N_ELEM);

        // Abort mid-DRAIN after three results.
        run_op(a_seq, b_rev, exp_t3, 1, 0, 3);
        @(negedge clk);
        out_ready_i = 1'b0;
        abort_i     = 1'b1;
        #1;
        check("drain_abort_valid_same_cycle", 32'(out_valid_o), 32'd1);
        check("drain_abort_data_held", 32'(out_data_o), 32'(exp_t3[3]));
        @(negedge clk);
        abort_i = 1'b0;
        #1;
        check("drain_abort_valid_next", 32'(out_valid_o), 32'd0);
        check("drain_abort_busy", 32'(busy_o), 32'd0);
        run_op(a_id, b_seq, exp_seq, 0, 2, N_ELEM);

        // Asynchronous reset mid-DRAIN after four results.
        run_op(a_seq, b_rev, exp_t3, 0, 0, 4);
        @(negedge clk);
        out_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid_o), 32'd0);
        check("async_rst_busy", 32'(busy_o), 32'd0);
        check("async_rst_in_ready", 32'(in_ready_o), 32'd1);
        check("async_rst_mats_zero", 32'((mat_A_o == '0) && (mat_B_o == '0)), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(a_seq, b_rev, exp_t3, 0, 1, N_ELEM);

        // Random operations checked against the reference product.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N_ELEM; i++) begin
                a_r[i] = DAT_W'($urandom);
                b_r[i] = DAT_W'($urandom);
            end
            exp_r = ref_matmul(a_r, b_r);
            run_op(a_r, b_r, exp_r, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), N_ELEM);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
